// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: divides mclk into a tick strobe and grants one enable per tick round-robin.
// Optional build macro IDLE_CNT_EN adds the idle_ticks utilisation counter output.
module clk_en_sched #(
    parameter int NUM_CORES = 4,
    parameter int DIV_W     = 8,
    localparam int SLOT_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 div_load,
    input  logic [DIV_W-1:0]     div_value,
    input  logic [NUM_CORES-1:0] core_req,
    output logic                 tick,
    output logic [NUM_CORES-1:0] core_en,
    output logic [SLOT_W-1:0]    slot_id,
`ifdef IDLE_CNT_EN
    output logic                 busy,
    output logic [15:0]          idle_ticks
`else
    output logic                 busy
`endif
);

    // state | meaning
    // IDLE  | stopped, counter held at 0, shadow divisor tracked continuously
    // RUN   | dividing mclk, issuing ticks and round-robin grants
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    div_active;
    logic [DIV_W-1:0]    div_shadow;
    logic [SLOT_W-1:0]   ptr;
    logic                terminal;
    logic                grant_found;
    logic [SLOT_W-1:0]   grant_idx;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        terminal  = 1'b0;
        case (state)
            S_IDLE: if (run) state_nxt = S_RUN;
            S_RUN: begin
                if (!run)                   state_nxt = S_IDLE;
                else if (cnt == div_active) terminal  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // First requester strictly after the last grant, wrapping around.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = ptr;
        for (int i = 1; i <= NUM_CORES; i++) begin
            idx = (int'(ptr) + i) % NUM_CORES;
            if (!grant_found && core_req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SLOT_W'(idx);
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            div_active <= DIV_W'(1);
            div_shadow <= DIV_W'(1);
            ptr        <= SLOT_W'(NUM_CORES - 1);
            tick       <= 1'b0;
            core_en    <= '0;
            slot_id    <= '0;
        end else begin
            if (div_load) div_shadow <= div_value;
            tick    <= 1'b0;
            core_en <= '0;
            // Shadow moves to active only at a period boundary or while stopped.
            if (state == S_IDLE) begin
                cnt        <= '0;
                div_active <= div_shadow;
            end else if (!run) begin
                cnt <= '0;
            end else if (terminal) begin
                cnt        <= '0;
                div_active <= div_shadow;
                tick       <= 1'b1;
                if (grant_found) begin
                    core_en <= NUM_CORES'(1) << grant_idx;
                    slot_id <= grant_idx;
                    ptr     <= grant_idx;
                end
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

    assign busy = (state == S_RUN);

`ifdef IDLE_CNT_EN
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)                                             idle_ticks <= '0;
        else if (div_load)                                      idle_ticks <= '0;
        else if (terminal && !grant_found && idle_ticks != 16'hFFFF) idle_ticks <= idle_ticks + 16'd1;
    end
`endif

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed vector table plus reset and randomized property sequences for clk_en_sched.
module tb_clk_en_sched;

    logic       mclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       div_load = 1'b0;
    logic [7:0] div_value = '0;
    logic [3:0] core_req = '0;
    logic       tick;
    logic [3:0] core_en;
    logic [1:0] slot_id;
    logic       busy;
`ifdef IDLE_CNT_EN
    logic [15:0] idle_ticks;
`endif

    int total = 0;
    int bad   = 0;

    always #5 mclk = ~mclk;

    clk_en_sched #(.NUM_CORES(4), .DIV_W(8)) dut (
        .mclk(mclk), .rst_n(rst_n), .run(run), .div_load(div_load),
        .div_value(div_value), .core_req(core_req), .tick(tick),
        .core_en(core_en), .slot_id(slot_id),
`ifdef IDLE_CNT_EN
        .busy(busy), .idle_ticks(idle_ticks)
`else
        .busy(busy)
`endif
    );

    typedef struct {
        logic       run;
        logic       dl;
        logic [7:0] dv;
        logic [3:0] req;
        logic       tick;
        logic [3:0] en;
        logic [1:0] slot;
        logic       busy;
        int         idle;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic dl, input logic [7:0] dv, input logic [3:0] req,
                       input logic t, input logic [3:0] en, input logic [1:0] s, input logic b,
                       input int idle = -1);
        vec_t v;
        v.run = r; v.dl = dl; v.dv = dv; v.req = req;
        v.tick = t; v.en = en; v.slot = s; v.busy = b; v.idle = idle;
        vq.push_back(v);
    endtask

    task automatic addn(input int n, input logic r, input logic [3:0] req, input logic [1:0] s);
        for (int k = 0; k < n; k++) add(r, 1'b0, 8'd0, req, 1'b0, 4'd0, s, r);
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        logic       exp_t [5];
        logic [3:0] exp_e [5];
        logic [1:0] exp_s [5];
        logic [3:0] req_prev;
        int         wait_cnt [4];

        // reset/default divide: tick every 2nd cycle, full rotation
        add(1,0,0,4'hF, 0,4'h0,0,1);
        add(1,0,0,4'hF, 0,4'h0,0,1);
        add(1,0,0,4'hF, 1,4'h1,0,1);
        add(1,0,0,4'hF, 0,4'h0,0,1);
        add(1,0,0,4'hF, 1,4'h2,1,1);
        add(1,0,0,4'hF, 0,4'h0,1,1);
        add(1,0,0,4'hF, 1,4'h4,2,1);
        add(1,0,0,4'hF, 0,4'h0,2,1);
        add(1,0,0,4'hF, 1,4'h8,3,1);
        add(1,0,0,4'hF, 0,4'h0,3,1);
        add(1,0,0,4'hF, 1,4'h1,0,1);
        // divisor 4 loaded mid-period, applies after the current period
        add(1,1,4,4'h5, 0,4'h0,0,1);
        add(1,0,0,4'h5, 1,4'h4,2,1);
        addn(4, 1, 4'h5, 2);
        add(1,0,0,4'h5, 1,4'h1,0,1);
        addn(4, 1, 4'h5, 0);
        add(1,0,0,4'h5, 1,4'h4,2,1);
        // no requesters for three ticks
        addn(4, 1, 4'h0, 2);
        add(1,0,0,4'h0, 1,4'h0,2,1);
        addn(4, 1, 4'h0, 2);
        add(1,0,0,4'h0, 1,4'h0,2,1);
        addn(4, 1, 4'h0, 2);
        add(1,0,0,4'h0, 1,4'h0,2,1, 3);
        // divisor 0: tick every cycle; pause and resume
        add(1,1,0,4'hF, 0,4'h0,2,1, 0);
        addn(3, 1, 4'hF, 2);
        add(1,0,0,4'hF, 1,4'h8,3,1);
        add(1,0,0,4'hF, 1,4'h1,0,1);
        add(1,0,0,4'hF, 1,4'h2,1,1);
        add(0,0,0,4'hF, 0,4'h0,1,0);
        add(0,0,0,4'hF, 0,4'h0,1,0);
        add(1,0,0,4'hF, 0,4'h0,1,1);
        add(1,0,0,4'hF, 1,4'h4,2,1);
        add(1,0,0,4'hF, 1,4'h8,3,1);
        // load 7 so a shadow value is pending when reset hits
        add(1,1,7,4'hF, 1,4'h1,0,1);

        rst_n = 1'b0;
        #12;
        chk("rst_tick", -1, 32'(tick), 0);
        chk("rst_en",   -1, 32'(core_en), 0);
        chk("rst_slot", -1, 32'(slot_id), 0);
        chk("rst_busy", -1, 32'(busy), 0);
`ifdef IDLE_CNT_EN
        chk("rst_idle", -1, 32'(idle_ticks), 0);
`endif
        @(negedge mclk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            run = vq[i].run; div_load = vq[i].dl; div_value = vq[i].dv; core_req = vq[i].req;
            step();
            chk("tick", i, 32'(tick), 32'(vq[i].tick));
            chk("core_en", i, 32'(core_en), 32'(vq[i].en));
            chk("slot_id", i, 32'(slot_id), 32'(vq[i].slot));
            chk("busy", i, 32'(busy), 32'(vq[i].busy));
`ifdef IDLE_CNT_EN
            if (vq[i].idle >= 0) chk("idle_ticks", i, 32'(idle_ticks), vq[i].idle);
`endif
        end
        div_load = 1'b0;

        // async reset mid-period with a pending shadow
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tick", -2, 32'(tick), 0);
        chk("arst_en",   -2, 32'(core_en), 0);
        chk("arst_busy", -2, 32'(busy), 0);
        run = 1'b0;
        @(negedge mclk);
        @(negedge mclk);
        rst_n = 1'b1;
        run = 1'b1; core_req = 4'hF;
        exp_t[0] = 0; exp_t[1] = 0; exp_t[2] = 1; exp_t[3] = 0; exp_t[4] = 1;
        exp_e[0] = 0; exp_e[1] = 0; exp_e[2] = 4'h1; exp_e[3] = 0; exp_e[4] = 4'h2;
        exp_s[0] = 0; exp_s[1] = 0; exp_s[2] = 0; exp_s[3] = 0; exp_s[4] = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_tick", i, 32'(tick), 32'(exp_t[i]));
            chk("post_rst_en", i, 32'(core_en), 32'(exp_e[i]));
            chk("post_rst_slot", i, 32'(slot_id), 32'(exp_s[i]));
        end

        // randomized properties
        for (int c = 0; c < 4; c++) wait_cnt[c] = 0;
        for (int n = 0; n < 4000; n++) begin
            run       = ($urandom_range(0, 29) != 0);
            div_load  = ($urandom_range(0, 39) == 0);
            div_value = 8'($urandom_range(0, 3));
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 7) == 0) core_req[c] = ~core_req[c];
            req_prev = core_req;
            step();
            chk("onehot0", n, 32'($countones(core_en) <= 1), 1);
            chk("en_with_tick", n, 32'(core_en == 0 || tick), 1);
            chk("en_was_req", n, 32'(core_en & ~req_prev), 0);
            if (tick) begin
                for (int c = 0; c < 4; c++) begin
                    if (core_en[c] || !req_prev[c]) wait_cnt[c] = 0;
                    else wait_cnt[c]++;
                    chk("starve", c, 32'(wait_cnt[c] < 4), 1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
